// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer between EX and the 4-stage multiplier (request latch, drain, flush, watchdog).
// Optional last-result cache enabled by defining MUL_RESCACHE_EN.
module mul_ctrl #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 4,
   parameter int WDOG    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_m1,
   input  logic [XLEN-1:0] req_m2,
   input  logic [1:0]      req_sign,
   input  logic            req_high,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_data,
   output logic            busy,
   output logic            wdog_err,
   output logic            mul_en,
   output logic            mul_word_sel,
   output logic [1:0]      mul_sign,
   output logic [XLEN-1:0] mul_m1,
   output logic [XLEN-1:0] mul_m2,
   output logic            mul_flush,
   input  logic            mul_done,
   input  logic [XLEN-1:0] mul_res
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   // Counter is wide enough for the watchdog limit even if it is misconfigured below MUL_LAT.
   localparam int CNT_TOP = (WDOG > MUL_LAT) ? WDOG : MUL_LAT + 1;
   localparam int CW = $clog2(CNT_TOP + 1);
   localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG - 1);

   state_t          state;
   logic [CW-1:0]   wdog_cnt;
   logic [XLEN-1:0] op_m1;
   logic [XLEN-1:0] op_m2;
   logic [1:0]      op_sign;
   logic            op_high;
   logic            accept;
   logic            done_ok;
   logic            wdog_hit;
   logic            hit;
   logic [XLEN-1:0] hit_res;

   assign accept   = (state == IDLE) && req_valid && !pipe_flush;
   assign done_ok  = (state == RUN) && !pipe_flush && mul_done;
   assign wdog_hit = (state == RUN) && !pipe_flush && !mul_done && (wdog_cnt == WDOG_LAST);

   assign req_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   // Flush must reach the multiplier in the same cycle, so these two bypass the state flops.
   assign mul_en       = (state == RUN) && !pipe_flush;
   assign mul_flush    = busy && pipe_flush;
   assign mul_m1       = op_m1;
   assign mul_m2       = op_m2;
   assign mul_sign     = op_sign;
   assign mul_word_sel = op_high;

`ifdef MUL_RESCACHE_EN
   logic            tag_valid;
   logic [XLEN-1:0] tag_m1;
   logic [XLEN-1:0] tag_m2;
   logic [1:0]      tag_sign;
   logic            tag_high;
   logic [XLEN-1:0] tag_res;

   assign hit = tag_valid && (tag_m1 == req_m1) && (tag_m2 == req_m2) &&
                (tag_sign == req_sign) && (tag_high == req_high);
   assign hit_res = tag_res;

   // Last-result tag: written on normal completion, dropped on watchdog abort (flush keeps it).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid <= 1'b0;
         tag_m1    <= {XLEN{1'b0}};
         tag_m2    <= {XLEN{1'b0}};
         tag_sign  <= 2'b00;
         tag_high  <= 1'b0;
         tag_res   <= {XLEN{1'b0}};
      end else if (done_ok) begin
         tag_valid <= 1'b1;
         tag_m1    <= op_m1;
         tag_m2    <= op_m2;
         tag_sign  <= op_sign;
         tag_high  <= op_high;
         tag_res   <= mul_res;
      end else if (wdog_hit) begin
         tag_valid <= 1'b0;
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_res = {XLEN{1'b0}};
`endif

   // Sequencer state, operand latch, watchdog counter and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wdog_cnt  <= {CW{1'b0}};
         op_m1     <= {XLEN{1'b0}};
         op_m2     <= {XLEN{1'b0}};
         op_sign   <= 2'b00;
         op_high   <= 1'b0;
         rsp_data  <= {XLEN{1'b0}};
         rsp_valid <= 1'b0;
         wdog_err  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         wdog_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && hit) begin
                  rsp_data  <= hit_res;
                  rsp_valid <= 1'b1;
               end else if (accept) begin
                  op_m1    <= req_m1;
                  op_m2    <= req_m2;
                  op_sign  <= req_sign;
                  op_high  <= req_high;
                  wdog_cnt <= {CW{1'b0}};
                  state    <= RUN;
               end
            end
            RUN: begin
               if (pipe_flush) begin
                  state <= IDLE;
               end else if (done_ok) begin
                  rsp_data  <= mul_res;
                  rsp_valid <= 1'b1;
                  state     <= DRAIN;
               end else if (wdog_hit) begin
                  wdog_err <= 1'b1;
                  state    <= IDLE;
               end else begin
                  wdog_cnt <= wdog_cnt + CW'(1);
               end
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
